// File: rtl/rst_release_sequencer.sv
// rst_release_sequencer: holds a group of downstream blocks in reset, then
// releases them one at a time, from bit 0 upward, with programmable gaps.
// A soft request restarts the whole sequence from the hold phase.
// Optional watchdog, compiled in by defining RST_SEQ_WATCHDOG_EN: while the
// sequence is idle in RUN, a missed service window triggers a restart.
module rst_release_sequencer #(
    parameter int NUM_OUT        = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4,
    parameter int WDOG_TIMEOUT   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               soft_rst_req,
    output logic               soft_rst_ack,
    output logic [NUM_OUT-1:0] rst_out,
    output logic               seq_busy,
    output logic               seq_done,
    input  logic               wdog_kick,
    output logic               wdog_fired
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int SW = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
    localparam int IW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [HW-1:0]      hold_cnt, hold_n;
    logic [SW-1:0]      stag_cnt, stag_n;
    logic [IW-1:0]      idx, idx_n;
    logic [NUM_OUT-1:0] out_n;
    logic               done_n, ack_n, busy_n;
    logic               restart;

`ifdef RST_SEQ_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_TIMEOUT);

    logic [WW-1:0] wdog_cnt, wdog_cnt_n;
    logic          wdog_trig;
    logic          fired_n;

    // Watchdog counts only while idle in RUN; a kick always beats the timeout.
    always_comb begin
        wdog_cnt_n = '0;
        wdog_trig  = 1'b0;
        fired_n    = wdog_fired;
        if (state == RUN && !wdog_kick) begin
            if (wdog_cnt == WW'(WDOG_TIMEOUT - 1)) begin
                wdog_trig = 1'b1;
                fired_n   = 1'b1;
            end else begin
                wdog_cnt_n = wdog_cnt + 1'b1;
            end
        end
    end

    // Watchdog counter and the sticky fired flag, cleared only by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt   <= '0;
            wdog_fired <= 1'b0;
        end else begin
            wdog_cnt   <= wdog_cnt_n;
            wdog_fired <= fired_n;
        end
    end

    assign restart = soft_rst_req | wdog_trig;
`else
    localparam int unused_wdog_timeout = WDOG_TIMEOUT;
    logic unused_wdog_kick;

    assign unused_wdog_kick = wdog_kick;
    assign wdog_fired       = 1'b0;
    assign restart          = soft_rst_req;
`endif

    // Next-state and next-output logic; a restart overrides normal progress.
    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        stag_n  = stag_cnt;
        idx_n   = idx;
        out_n   = rst_out;
        done_n  = 1'b0;
        ack_n   = 1'b0;

        case (state)
            ASSERT: begin
                out_n = {NUM_OUT{1'b1}};
                if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                    hold_n = '0;
                    stag_n = '0;
                    if (NUM_OUT == 1) begin
                        out_n   = '0;
                        idx_n   = '0;
                        done_n  = 1'b1;
                        state_n = RUN;
                    end else begin
                        out_n[0] = 1'b0;
                        idx_n    = IW'(1);
                        state_n  = RELEASE;
                    end
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (stag_cnt == SW'(STAGGER_CYCLES - 1)) begin
                    stag_n     = '0;
                    out_n[idx] = 1'b0;
                    if (idx == IW'(NUM_OUT - 1)) begin
                        idx_n   = '0;
                        done_n  = 1'b1;
                        state_n = RUN;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end else begin
                    stag_n = stag_cnt + 1'b1;
                end
            end
            RUN: begin
                out_n = '0;
            end
            default: begin
                state_n = ASSERT;
                out_n   = {NUM_OUT{1'b1}};
                hold_n  = '0;
                stag_n  = '0;
                idx_n   = '0;
            end
        endcase

        if (restart) begin
            state_n = ASSERT;
            out_n   = {NUM_OUT{1'b1}};
            hold_n  = '0;
            stag_n  = '0;
            idx_n   = '0;
            done_n  = 1'b0;
            ack_n   = 1'b1;
        end

        busy_n = (state_n != RUN);
    end

    // State, counters and all outputs are registered; rst restores the hold phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ASSERT;
            hold_cnt     <= '0;
            stag_cnt     <= '0;
            idx          <= '0;
            rst_out      <= {NUM_OUT{1'b1}};
            seq_busy     <= 1'b1;
            seq_done     <= 1'b0;
            soft_rst_ack <= 1'b0;
        end else begin
            state        <= state_n;
            hold_cnt     <= hold_n;
            stag_cnt     <= stag_n;
            idx          <= idx_n;
            rst_out      <= out_n;
            seq_busy     <= busy_n;
            seq_done     <= done_n;
            soft_rst_ack <= ack_n;
        end
    end

endmodule

// File: tb/tb_rst_release_sequencer.sv
// tb_rst_release_sequencer: directed test of the reset release sequencer with
// default sizing and WDOG_TIMEOUT = 8. Watchdog checks depend on whether
// RST_SEQ_WATCHDOG_EN is defined for the build.
module tb_rst_release_sequencer;

    logic       clk;
    logic       rst;
    logic       soft_rst_req;
    logic       soft_rst_ack;
    logic [3:0] rst_out;
    logic       seq_busy;
    logic       seq_done;
    logic       wdog_kick;
    logic       wdog_fired;

    int compared;
    int mismatched;

    rst_release_sequencer #(
        .NUM_OUT(4),
        .HOLD_CYCLES(16),
        .STAGGER_CYCLES(4),
        .WDOG_TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .soft_rst_req(soft_rst_req),
        .soft_rst_ack(soft_rst_ack),
        .rst_out(rst_out),
        .seq_busy(seq_busy),
        .seq_done(seq_done),
        .wdog_kick(wdog_kick),
        .wdog_fired(wdog_fired)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic req, input logic kick);
        rst          = r;
        soft_rst_req = req;
        wdog_kick    = kick;
    endtask

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Full release sequence starting from the edge that began the hold phase.
    task automatic expectSequence(input string tag);
        tick(15);
        checkOutput({tag, "_hold"}, 32'(rst_out), 32'hF);
        checkOutput({tag, "_busy"}, 32'(seq_busy), 32'h1);
        tick(1);
        checkOutput({tag, "_r0"}, 32'(rst_out), 32'hE);
        tick(4);
        checkOutput({tag, "_r1"}, 32'(rst_out), 32'hC);
        tick(4);
        checkOutput({tag, "_r2"}, 32'(rst_out), 32'h8);
        checkOutput({tag, "_nodone"}, 32'(seq_done), 32'h0);
        tick(4);
        checkOutput({tag, "_r3"}, 32'(rst_out), 32'h0);
        checkOutput({tag, "_done"}, 32'(seq_done), 32'h1);
        checkOutput({tag, "_idle"}, 32'(seq_busy), 32'h0);
        tick(1);
        checkOutput({tag, "_donepulse"}, 32'(seq_done), 32'h0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        // Kick held high keeps the watchdog quiet outside its own test.
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick(3);
        checkOutput("reset_out", 32'(rst_out), 32'hF);
        checkOutput("reset_busy", 32'(seq_busy), 32'h1);
        checkOutput("reset_done", 32'(seq_done), 32'h0);
        checkOutput("reset_ack", 32'(soft_rst_ack), 32'h0);
        checkOutput("reset_fired", 32'(wdog_fired), 32'h0);

        // Power-up release
        applyStimulus(1'b0, 1'b0, 1'b1);
        expectSequence("power");

        // One-cycle soft request from RUN, then abort at 1100
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(1);
        checkOutput("soft_ack", 32'(soft_rst_ack), 32'h1);
        checkOutput("soft_out", 32'(rst_out), 32'hF);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(1);
        checkOutput("soft_ackpulse", 32'(soft_rst_ack), 32'h0);
        tick(14);
        checkOutput("soft_hold", 32'(rst_out), 32'hF);
        tick(1);
        checkOutput("soft_r0", 32'(rst_out), 32'hE);
        tick(4);
        checkOutput("soft_r1", 32'(rst_out), 32'hC);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(1);
        checkOutput("abort_out", 32'(rst_out), 32'hF);
        checkOutput("abort_ack", 32'(soft_rst_ack), 32'h1);
        checkOutput("abort_done", 32'(seq_done), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        expectSequence("abort_rerun");

        // Request landing on the completion edge wins
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(15);
        tick(1);
        checkOutput("prec_r0", 32'(rst_out), 32'hE);
        tick(8);
        checkOutput("prec_r2", 32'(rst_out), 32'h8);
        tick(3);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(1);
        checkOutput("prec_done", 32'(seq_done), 32'h0);
        checkOutput("prec_out", 32'(rst_out), 32'hF);
        checkOutput("prec_ack", 32'(soft_rst_ack), 32'h1);

        // Held request: request stays high for 10 edges in total
        for (int i = 0; i < 9; i++) begin
            tick(1);
            checkOutput($sformatf("held_ack%0d", i), 32'(soft_rst_ack), 32'h1);
            checkOutput($sformatf("held_out%0d", i), 32'(rst_out), 32'hF);
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        expectSequence("held");

        // rst for one cycle while rst_out = 1000, with a request also high
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(24);
        checkOutput("midrst_pre", 32'(rst_out), 32'h8);
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick(1);
        checkOutput("midrst_out", 32'(rst_out), 32'hF);
        checkOutput("midrst_ack", 32'(soft_rst_ack), 32'h0);
        checkOutput("midrst_busy", 32'(seq_busy), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        expectSequence("midrst");

`ifdef RST_SEQ_WATCHDOG_EN
        // No kicks in RUN: trigger on the 8th edge
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(7);
        checkOutput("wdog_quiet_ack", 32'(soft_rst_ack), 32'h0);
        checkOutput("wdog_quiet_fired", 32'(wdog_fired), 32'h0);
        tick(1);
        checkOutput("wdog_ack", 32'(soft_rst_ack), 32'h1);
        checkOutput("wdog_fired", 32'(wdog_fired), 32'h1);
        checkOutput("wdog_out", 32'(rst_out), 32'hF);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(1);
        checkOutput("wdog_ackpulse", 32'(soft_rst_ack), 32'h0);
        tick(14);
        tick(1);
        checkOutput("wdog_rerun_r0", 32'(rst_out), 32'hE);
        tick(12);
        checkOutput("wdog_rerun_done", 32'(seq_done), 32'h1);
        // Kick every 5th edge: never times out
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b0, 1'b0, (i % 5) == 4);
            tick(1);
            checkOutput($sformatf("kick_ack%0d", i), 32'(soft_rst_ack), 32'h0);
        end
        checkOutput("kick_out", 32'(rst_out), 32'h0);
        checkOutput("kick_sticky", 32'(wdog_fired), 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        tick(1);
        checkOutput("wdog_clear", 32'(wdog_fired), 32'h0);
`else
        // Watchdog compiled out: no kicks, nothing happens
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            checkOutput($sformatf("nowdog_ack%0d", i), 32'(soft_rst_ack), 32'h0);
        end
        checkOutput("nowdog_fired", 32'(wdog_fired), 32'h0);
        checkOutput("nowdog_out", 32'(rst_out), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
